// File: rtl/memory_decompression_reader.sv
// memory_decompression_reader
// Burst read engine for the compressed store. Fetches COMPRESS_BW-bit words
// over a one-cycle-latency read port, expands each to BW bits by appending a
// fill pattern, and streams them out through a 2-entry FIFO with a last flag.
// Reads are credit-limited so the FIFO can never overflow.
module memory_decompression_reader #(
  parameter int BW          = 16,
  parameter int COMPRESS_BW = 8,
  parameter int MW          = 16,
  parameter int AW          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [AW-1:0]          req_len,
  input  logic                   req_fill_mode,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_rd_addr,
  input  logic [COMPRESS_BW-1:0] mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BW-1:0]          out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int FW = BW - COMPRESS_BW;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          r_state, w_next;

  // latched request and read progress
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_remain;      // reads still to issue, minus one
  logic            r_fill;

  // one read in flight: data shows up on mem_rd_data this cycle
  logic            r_inflight;
  logic            r_inflight_last;

  // 2-entry output FIFO: head is the word presented on the output
  logic [BW-1:0]   r_head_data, r_tail_data;
  logic            r_head_last, r_tail_last;
  logic [1:0]      r_cnt;

  logic            w_accept, w_issue, w_issue_last, w_push, w_pop;
  logic [2:0]      w_used;
  logic [FW-1:0]   w_fill;
  logic [BW-1:0]   w_push_data;
  logic [AW-1:0]   w_addr_nxt;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_pop        = (r_cnt != 2'd0) && out_ready;
  assign w_push       = r_inflight;
  // slots committed after this cycle's pop; a read needs one free slot
  assign w_used       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_READ) && (w_used < 3'd2);
  assign w_issue_last = w_issue && (r_remain == '0);
  assign w_addr_nxt   = (r_addr == AW'(MW - 1)) ? '0 : r_addr + AW'(1);

  // fill pattern: zero, or only the MSB set (midpoint of the lost range)
  always_comb begin
    w_fill         = '0;
    w_fill[FW-1]   = r_fill;
  end

  assign w_push_data = {mem_rd_data, w_fill};

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  if (w_issue_last) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && r_head_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    mem_rd_en   = w_issue;
    mem_rd_addr = w_issue ? r_addr : '0;
    out_valid   = (r_cnt != 2'd0);
    out_data    = r_head_data;
    out_last    = (r_cnt != 2'd0) && r_head_last;
  end

  // request latch, address walk and remaining-count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_fill   <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_remain <= req_len;
      r_fill   <= req_fill_mode;
    end else if (w_issue) begin
      r_addr   <= w_addr_nxt;
      r_remain <= r_remain - AW'(1);
    end
  end

  // in-flight tracker; clearing it on reset drops any late-returning data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
    end
  end

  // output FIFO: push from returning read data, pop on handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head_data <= w_push_data;
            r_head_last <= r_inflight_last;
          end else begin
            r_tail_data <= w_push_data;
            r_tail_last <= r_inflight_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // credit keeps this to occupancy 1; the 2-entry path is kept coherent anyway
          if (r_cnt == 2'd2) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            r_tail_data <= w_push_data;
            r_tail_last <= r_inflight_last;
          end else begin
            r_head_data <= w_push_data;
            r_head_last <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/memory_decompression_reader.md
# memory_decompression_reader

Burst read engine for the compressed-memory path. It accepts a read request (start address, length, fill mode) and fetches `COMPRESS_BW`-bit compressed words from the compressed store over a one-cycle-latency read port. It expands each word to `BW` bits and delivers it on a valid/ready stream with a last-word marker. It is the read-side counterpart of the compressing writer that truncates `BW`-bit words to their upper `COMPRESS_BW` bits.

## Interface
- `BW`, 16, width of a decompressed output word; must exceed `COMPRESS_BW`.
- `COMPRESS_BW`, 8, width of a stored compressed word.
- `MW`, 16, memory depth in words.
- `AW`, 4, address width; `MW` = 2^`AW`.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  1  burst request present.
- `req_ready`  output  1  engine idle; a request is accepted on any edge where `req_valid && req_ready`.
- `req_addr`  input  AW  start address.
- `req_len`  input  AW  burst length minus 1 (1 to `MW` words).
- `req_fill_mode`  input  1  fill mode: 0 = zero fill, 1 = midpoint fill.
- `mem_rd_en`  output  1  memory read strobe.
- `mem_rd_addr`  output  AW  memory read address.
- `mem_rd_data`  input  COMPRESS_BW  read data; valid in the cycle after the edge that sampled `mem_rd_en`.
- `out_valid`  output  1  expanded word available.
- `out_ready`  input  1  consumer accepts the word.
- `out_data`  output  BW  expanded word.
- `out_last`  output  1  final word of the burst; qualified by `out_valid`.
- `busy`  output  1  burst in progress (not IDLE).

## Operation
- States:
  - IDLE: `req_ready`=1.
  - READ: issuing reads.
  - DRAIN: all reads issued; waiting for the output to empty.
- IDLE -> READ on request acceptance. The engine latches `req_addr`, `req_len` and `req_fill_mode`; later changes on the `req_*` inputs are ignored until IDLE.
- READ issues one read per cycle while credit allows.
  - Credit rule: issue only when occupancy + in-flight − (`out_valid && out_ready`) < 2.
  - Occupancy is the number of entries in a 2-entry output FIFO; in-flight is 0 or 1.
- After each issue, the address increments modulo `MW` (15 -> 0, no error) and the remaining count decrements.
- READ -> DRAIN on the edge that issues the final read.
- DRAIN -> IDLE on the edge where the `out_last` word handshakes.
- Expansion: `out_data` = {`mem_rd_data`, fill}. The fill is `BW`−`COMPRESS_BW` bits:
  - Mode 0: all zeros.
  - Mode 1: MSB of the fill = 1, remaining bits zero (0x80 for the defaults).
- `out_last` is set only on the FIFO entry holding the burst's final word.
- The FIFO never overflows; the credit rule guarantees this.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- Simultaneous push and pop on a full FIFO cannot occur. On a 1-entry FIFO, push and pop in the same cycle keep occupancy at 1.
- Reset (`rst` low, any time, including mid-burst):
  - State goes to IDLE, the FIFO empties, and in-flight is cleared.
  - Read data returning after reset release is discarded.
  - `req_ready`=1, `busy`=0, and all other outputs are 0 while in reset.

## Timing
- E0 = acceptance edge.
  - `mem_rd_en`=1 with `mem_rd_addr`=start during the cycle after E0.
  - Memory samples at E1; data is captured into the FIFO at E2.
  - `out_valid`=1 from E2 onward.
- Latency: 2 cycles from acceptance to first `out_valid`.
- Throughput: with `out_ready` held high, 1 word per cycle. An N-word burst presents its last word in the cycle after edge E(N+1). The engine is back in IDLE after that word's handshake edge, and the earliest next acceptance is the following edge.
- Backpressure: at most 2 words are buffered or in flight. `mem_rd_en` deasserts within 1 cycle of `out_ready` falling with the FIFO full.
- `req_ready` and `busy` are registered state decodes; they have no combinational path from `req_valid`.
- Output reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `busy`=0, `req_ready`=1.

## Test plan
- **Reset:** assert `rst`=0 mid-clock -> all outputs take their reset values immediately, without waiting for an edge; release -> `req_ready`=1.
- **Basic burst:** memory holds 0xA0+addr; request addr=2, len=3, mode 0, `out_ready`=1 -> `out_data` is 0xA200, 0xA300, 0xA400, 0xA500 on consecutive cycles; `out_last` only on 0xA500; first `out_valid` 2 cycles after acceptance.
- **Wrap:** request addr=14, len=3 -> reads 14, 15, 0, 1 in that order; output 0xAE00, 0xAF00, 0xA000, 0xA100.
- **Midpoint fill:** mode 1 over words 0x7F and 0x00 -> output 0x7F80, 0x0080.
- **Backpressure:** 8-word burst with `out_ready` low for 5 cycles after the 2nd word -> at most 2 words pending, `out_data` stable while stalled, all 8 words delivered once each in order.
- **Reset mid-burst:** assert `rst` after the 3rd word of a 16-word burst -> outputs clear at once; after release, a new 2-word burst at addr=0 returns exactly 0xA000 and 0xA100 with correct `out_last`.
